// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the 5-stage RV64 core.
// Captures the control decoder's bundle and the decode-stage operands one
// cycle later. Detects load-use hazards, raises stall and inserts bubbles.
// A taken-branch flush squashes the slot and overrides any stall.
// Optional build macro ID_EX_HAZARD_CNT_EN adds a hz_count output. It counts
// the bubbles inserted because of a load-use stall.
module id_ex_stage #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  // decode slot
  input  logic            id_valid,
  input  logic            id_alu_src,
  input  logic            id_mem_to_reg,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic [1:0]      id_alu_op,
  input  logic [3:0]      id_funct,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  // branch resolution from downstream
  input  logic            flush,
  // hazard handshake to IF/ID
  output logic            stall,
  // execute slot
  output logic            ex_valid,
  output logic            ex_alu_src,
  output logic            ex_mem_to_reg,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic [1:0]      ex_alu_op,
  output logic [3:0]      ex_funct,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd
`ifdef ID_EX_HAZARD_CNT_EN
  ,
  output logic [31:0]     hz_count
`endif
);

  // Source-register usage. Every supported op (ld, sd, beq, R-type) reads
  // rs1. rs2 is read unless the second ALU operand is the immediate, and a
  // store still reads rs2 as its store data.
  logic uses_rs1;
  logic uses_rs2;
  logic rs1_match;
  logic rs2_match;
  logic ex_is_load;
  logic hz;
  logic capture;

  // Load-use hazard detection against the instruction currently in EX.
  always_comb begin
    uses_rs1   = 1'b1;
    uses_rs2   = ~id_alu_src | id_mem_write;
    rs1_match  = (ex_rd == id_rs1) & uses_rs1;
    rs2_match  = (ex_rd == id_rs2) & uses_rs2;
    // A load into x0 never produces a value, so it never stalls.
    ex_is_load = ex_valid & ex_mem_read & (ex_rd != '0);
    hz         = ex_is_load & id_valid & (rs1_match | rs2_match);
    // A flush wins over the stall so that upstream can redirect the PC.
    stall      = hz & ~flush;
    // Flush, hazard and empty/illegal slot each load a bubble.
    capture    = ~flush & ~hz & id_valid;
  end

  // Control bundle: captured on a real instruction, otherwise cleared to a
  // bubble. mem_to_reg is masked with reg_write because the decoder drives
  // x on it when nothing is written back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= 2'b00;
    end else if (capture) begin
      ex_valid      <= 1'b1;
      ex_alu_src    <= id_alu_src;
      ex_mem_to_reg <= id_mem_to_reg & id_reg_write;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_branch     <= id_branch;
      ex_alu_op     <= id_alu_op;
    end else begin
      ex_valid      <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= 2'b00;
    end
  end

  // Data and address fields load only on capture. A bubble leaves them at
  // their previous values, which is harmless because every control is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_funct    <= '0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
    end else if (capture) begin
      ex_funct    <= id_funct;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
    end
  end

`ifdef ID_EX_HAZARD_CNT_EN
  // Count the bubbles caused by load-use stalls. The counter wraps naturally
  // at 32 bits. Flush and invalid bubbles are excluded because stall is low
  // for them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz_count <= 32'd0;
    end else if (stall) begin
      hz_count <= hz_count + 32'd1;
    end
  end
`endif

endmodule
